// File: rtl/irq_pkg.sv
// Shared encodings for the timer interrupt controller: FSM states,
// register offsets and STATUS field positions.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

    localparam logic [1:0] REG_PEND   = 2'd0;
    localparam logic [1:0] REG_MASK   = 2'd1;
    localparam logic [1:0] REG_EDGE   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int ST_BUSY_BIT  = 31;
    localparam int ST_STATE_LSB = 8;
    localparam int ST_ID_LSB    = 0;

    function automatic logic [7:0] onehot8(input logic [2:0] id);
        onehot8 = 8'b1 << id;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins; valid when any bit is set.
module irq_prio_enc #(
    parameter int N_SRC = 6
) (
    input  logic [N_SRC-1:0] vec,
    output logic             valid,
    output logic [2:0]       idx
);

    always_comb begin
        valid = |vec;
        idx   = 3'd0;
        // Scan downward so the lowest set index is the last one assigned.
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (vec[i]) idx = 3'(i);
        end
    end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Interrupt controller: pending/mask/edge registers, priority select and a
// request/ack/EOI handshake that presents one interrupt at a time to CP0.
module timer_irq_ctrl
    import irq_pkg::*;
#(
    parameter int N_SRC = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_irq,
    input  logic [31:2]      Addr,
    input  logic             WE,
    input  logic [31:0]      Din,
    input  logic             int_ack,
    output logic [31:0]      Dout,
    output logic [N_SRC-1:0] hwint,
    output logic             int_req
);

    logic [N_SRC-1:0] pend, mask, edge_sel, prev;
    state_t           state;
    logic [2:0]       cur_id;

    logic             wr_pend, wr_mask, wr_edge, eoi;
    logic [N_SRC-1:0] set_vec, clr_vec, cur_oh, win_oh;
    logic [7:0]       cur_oh8, win_oh8;
    logic             win_vld, cur_active;
    logic [2:0]       win_id;
    logic             unused_ok;

    assign unused_ok = ^{Addr[31:4], Din[31:N_SRC]};

    assign wr_pend = WE && (Addr[3:2] == REG_PEND);
    assign wr_mask = WE && (Addr[3:2] == REG_MASK);
    assign wr_edge = WE && (Addr[3:2] == REG_EDGE);
    assign eoi     = WE && (Addr[3:2] == REG_STATUS) && (state == SVC);

    assign cur_oh8 = onehot8(cur_id);
    assign cur_oh  = cur_oh8[N_SRC-1:0];

    irq_prio_enc #(.N_SRC(N_SRC)) u_prio (
        .vec   (pend & mask),
        .valid (win_vld),
        .idx   (win_id)
    );

    assign win_oh8    = onehot8(win_id);
    assign win_oh     = win_oh8[N_SRC-1:0];
    assign cur_active = |(pend & mask & cur_oh);

    assign set_vec = (edge_sel & src_irq & ~prev) | (~edge_sel & src_irq);
    assign clr_vec = (wr_pend ? Din[N_SRC-1:0] : '0) | (eoi ? cur_oh : '0);

    // Register file and pending latch; a new set always beats a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend     <= '0;
            mask     <= '0;
            edge_sel <= '0;
            prev     <= '0;
        end else begin
            prev <= src_irq;
            pend <= (pend & ~clr_vec) | set_vec;
            if (wr_mask) mask     <= Din[N_SRC-1:0];
            if (wr_edge) edge_sel <= Din[N_SRC-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cur_id  <= 3'd0;
            hwint   <= '0;
            int_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state   <= REQ;
                        cur_id  <= win_id;
                        hwint   <= win_oh;
                        int_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        state   <= SVC;
                        hwint   <= '0;
                        int_req <= 1'b0;
                    end else if (!cur_active) begin
                        state   <= IDLE;
                        hwint   <= '0;
                        int_req <= 1'b0;
                    end
                end
                SVC: begin
                    if (eoi) state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    hwint   <= '0;
                    int_req <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (Addr[3:2])
            REG_PEND: Dout[N_SRC-1:0] = pend;
            REG_MASK: Dout[N_SRC-1:0] = mask;
            REG_EDGE: Dout[N_SRC-1:0] = edge_sel;
            default: begin
                Dout[ST_BUSY_BIT]                  = (state != IDLE);
                Dout[ST_STATE_LSB+1:ST_STATE_LSB] = state;
                Dout[ST_ID_LSB+2:ST_ID_LSB]       = cur_id;
            end
        endcase
    end

endmodule
